// File: rtl/hamming_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// hamming_tx_serializer_if
// Bundles the word-side and bit-side handshakes of hamming_tx_serializer.
//   in_data/in_valid/in_ready/inj_pos : 4-bit word input with injection position
//   out_bit/out_valid/out_ready/out_last : 1-bit serial codeword stream
//   out_code   : codeword currently being shifted (after injection)
//   words_sent : wrapping count of completed codewords
// modport slave  : the serializer itself
// modport master : the environment driving words and consuming bits
// ---------------------------------------------------------------------------
interface hamming_tx_serializer_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       inj_pos;
    logic             out_bit;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic [6:0]       out_code;
    logic [CNT_W-1:0] words_sent;

    modport slave (
        input  in_data, in_valid, inj_pos, out_ready,
        output in_ready, out_bit, out_valid, out_last, out_code, words_sent
    );

    modport master (
        output in_data, in_valid, inj_pos, out_ready,
        input  in_ready, out_bit, out_valid, out_last, out_code, words_sent
    );
endinterface

// File: rtl/hamming_tx_serializer.sv
// ---------------------------------------------------------------------------
// hamming_tx_serializer
// Encodes 4-bit words into Hamming(7,4) codewords (same parity-check matrix
// as the receive-side decoder), optionally flips one codeword bit for fault
// injection, and shifts each codeword out MSB-first on a 1-bit stream.
// One holding register lets the next word wait while the current one shifts,
// so words leave back-to-back with no gap cycles.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : hamming_tx_serializer_if.slave (word input, serial output,
//           out_code and words_sent)
// Parameters:
//   INJ_EN : 1 = inj_pos honoured, 0 = inj_pos ignored
//   CNT_W  : width of words_sent
// ---------------------------------------------------------------------------
module hamming_tx_serializer #(
    parameter bit INJ_EN = 1'b1,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hamming_tx_serializer_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // c6..c4 = w3..w1, c2 = w0; parity bits sit at positions 1, 2 and 4.
    function automatic logic [6:0] hamming_encode(input logic [3:0] w);
        logic [6:0] c;
        c[6] = w[3];
        c[5] = w[2];
        c[4] = w[1];
        c[2] = w[0];
        c[3] = w[3] ^ w[2] ^ w[1];
        c[1] = w[3] ^ w[2] ^ w[0];
        c[0] = w[3] ^ w[1] ^ w[0];
        return c;
    endfunction

    // Position p (1..7) flips codeword bit p-1; position 0 flips nothing.
    function automatic logic [6:0] inj_mask(input logic [2:0] pos);
        logic [6:0] m;
        case (pos)
            3'd1:    m = 7'b000_0001;
            3'd2:    m = 7'b000_0010;
            3'd3:    m = 7'b000_0100;
            3'd4:    m = 7'b000_1000;
            3'd5:    m = 7'b001_0000;
            3'd6:    m = 7'b010_0000;
            3'd7:    m = 7'b100_0000;
            default: m = 7'b000_0000;
        endcase
        return m;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [6:0]       code_r;
    logic [6:0]       code_s;
    logic [2:0]       idx_r;
    logic [2:0]       idx_s;
    logic [6:0]       hold_r;
    logic [6:0]       hold_s;
    logic             hold_full_r;
    logic             hold_full_s;
    logic [CNT_W-1:0] words_sent_r;
    logic [CNT_W-1:0] words_sent_s;

    logic             in_ready_s;
    logic             out_valid_s;
    logic             out_bit_s;
    logic             out_last_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             last_fire_s;
    logic             shifter_free_s;
    logic [6:0]       mask_s;
    logic [6:0]       new_code_s;

    // State register: FSM state, shifter, holding register and word counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            code_r       <= 7'b000_0000;
            idx_r        <= 3'd6;
            hold_r       <= 7'b000_0000;
            hold_full_r  <= 1'b0;
            words_sent_r <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_s;
            code_r       <= code_s;
            idx_r        <= idx_s;
            hold_r       <= hold_s;
            hold_full_r  <= hold_full_s;
            words_sent_r <= words_sent_s;
        end
    end

    // Next-state logic: load shifter/HOLD, advance the bit index, count words.
    always_comb begin
        state_s      = state_r;
        code_s       = code_r;
        idx_s        = idx_r;
        hold_s       = hold_r;
        hold_full_s  = hold_full_r;
        words_sent_s = words_sent_r;

        if (INJ_EN) begin
            mask_s = inj_mask(bus.inj_pos);
        end else begin
            mask_s = 7'b000_0000;
        end
        new_code_s = hamming_encode(bus.in_data) ^ mask_s;

        in_fire_s      = bus.in_valid & in_ready_s;
        out_fire_s     = out_valid_s & bus.out_ready;
        last_fire_s    = out_fire_s & out_last_s;
        // A last-bit transfer frees the shifter on the same edge, which is
        // what removes the gap between consecutive words.
        shifter_free_s = (state_r == IDLE) | last_fire_s;

        if (shifter_free_s) begin
            idx_s = 3'd6;
            if (hold_full_r) begin
                code_s  = hold_r;
                state_s = SHIFT;
                if (in_fire_s) begin
                    hold_s      = new_code_s;
                    hold_full_s = 1'b1;
                end else begin
                    hold_full_s = 1'b0;
                end
            end else if (in_fire_s) begin
                code_s  = new_code_s;
                state_s = SHIFT;
            end else begin
                state_s = IDLE;
            end
        end else begin
            if (out_fire_s) begin
                idx_s = idx_r - 3'd1;
            end else begin
                idx_s = idx_r;
            end
            if (in_fire_s) begin
                hold_s      = new_code_s;
                hold_full_s = 1'b1;
            end else begin
                hold_full_s = hold_full_r;
            end
        end

        if (last_fire_s) begin
            words_sent_s = words_sent_r + CNT_W'(1);
        end else begin
            words_sent_s = words_sent_r;
        end
    end

    // Output logic: every output is decoded straight from flops (plus rst_n).
    always_comb begin
        in_ready_s  = rst_n & ~hold_full_r;
        out_valid_s = (state_r == SHIFT);
        out_bit_s   = code_r[idx_r];
        out_last_s  = (state_r == SHIFT) & (idx_r == 3'd0);
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_s;
    assign bus.out_bit    = out_bit_s;
    assign bus.out_last   = out_last_s;
    assign bus.out_code   = code_r;
    assign bus.words_sent = words_sent_r;

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_hamming_tx_serializer
// Two serializers share one stimulus stream: dut0 (INJ_EN=1, CNT_W=8) and
// dut1 (INJ_EN=0, CNT_W=2). Accepted words push expected codewords into a
// scoreboard; a negedge monitor rebuilds each serial codeword and pops.
// ---------------------------------------------------------------------------
module tb_hamming_tx_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       in_valid = 1'b0;
    logic [2:0] inj_pos = 3'd0;
    logic       out_ready;
    logic       ready_fix = 1'b0;
    logic       rnd_ready = 1'b0;
    logic       rnd_bit = 1'b0;

    always #5 clk = ~clk;

    assign out_ready = rnd_ready ? rnd_bit : ready_fix;

    hamming_tx_serializer_if #(.CNT_W(8)) if0 ();
    hamming_tx_serializer_if #(.CNT_W(2)) if1 ();

    assign if0.in_data   = in_data;
    assign if0.in_valid  = in_valid;
    assign if0.inj_pos   = inj_pos;
    assign if0.out_ready = out_ready;
    assign if1.in_data   = in_data;
    assign if1.in_valid  = in_valid;
    assign if1.inj_pos   = inj_pos;
    assign if1.out_ready = out_ready;

    hamming_tx_serializer #(.INJ_EN(1'b1), .CNT_W(8)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    hamming_tx_serializer #(.INJ_EN(1'b0), .CNT_W(2)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    int         errors = 0;
    int         checks = 0;
    logic [6:0] q0[$];
    logic [6:0] q1[$];
    logic [6:0] acc0 = 7'd0;
    logic [6:0] acc1 = 7'd0;
    logic [6:0] e0;
    logic [6:0] e1;
    int         bitcnt = 0;
    int         exp_ws = 0;
    logic       mon_en = 1'b0;
    logic       prev_stall = 1'b0;
    logic       prev_bit = 1'b0;
    logic       prev_last = 1'b0;
    logic [6:0] prev_code = 7'd0;
    logic [2:0] last_synd = 3'd0;
    logic [3:0] last_data = 4'd0;
    logic [6:0] last_code0 = 7'd0;
    logic [6:0] last_code1 = 7'd0;
    logic       saw_block = 1'b0;
    time        acc_t = 0;
    time        done_t = 0;

    function automatic logic [6:0] enc(input logic [3:0] w);
        logic [6:0] c;
        c = {w[3], w[2], w[1], w[3] ^ w[2] ^ w[1], w[0], w[3] ^ w[2] ^ w[0], w[3] ^ w[1] ^ w[0]};
        return c;
    endfunction

    function automatic logic [6:0] flip(input logic [2:0] p);
        logic [6:0] one;
        one = 7'b000_0001;
        if (p == 3'd0) return 7'b000_0000;
        else return one << (p - 3'd1);
    endfunction

    // Syndrome bit k is the parity over all positions whose index has bit k set.
    function automatic logic [2:0] synd(input logic [6:0] c);
        logic [2:0] s;
        s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
        s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
        s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Random out_ready source used during the stall test.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: serial reassembly, scoreboard pop, stall stability, counters.
    initial begin
        logic [6:0] fixed;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("words_sent", if0.words_sent, exp_ws[7:0]);
                chk("words_sent_w2", if1.words_sent, exp_ws[1:0]);
                if (prev_stall) begin
                    chk("stall_valid", if0.out_valid, 1);
                    chk("stall_bit", if0.out_bit, prev_bit);
                    chk("stall_last", if0.out_last, prev_last);
                    chk("stall_code", if0.out_code, prev_code);
                end
            end
            if (!rst_n) begin
                q0.delete();
                q1.delete();
                bitcnt = 0;
                exp_ws = 0;
                prev_stall = 1'b0;
            end else if (mon_en) begin
                prev_stall = if0.out_valid & ~out_ready;
                prev_bit   = if0.out_bit;
                prev_last  = if0.out_last;
                prev_code  = if0.out_code;
                if (if0.out_valid && out_ready) begin
                    chk("bit_pending", q0.size() > 0, 1);
                    chk("dut1_valid", if1.out_valid, 1);
                    acc0 = {acc0[5:0], if0.out_bit};
                    acc1 = {acc1[5:0], if1.out_bit};
                    bitcnt++;
                    chk("out_last", if0.out_last, bitcnt == 7);
                    chk("dut1_last", if1.out_last, bitcnt == 7);
                    if (bitcnt == 7) begin
                        e0 = (q0.size() > 0) ? q0.pop_front() : 7'bxxx_xxxx;
                        e1 = (q1.size() > 0) ? q1.pop_front() : 7'bxxx_xxxx;
                        chk("serial_code", acc0, e0);
                        chk("out_code", if0.out_code, e0);
                        chk("dut1_serial", acc1, e1);
                        chk("dut1_out_code", if1.out_code, e1);
                        last_code0 = acc0;
                        last_code1 = if1.out_code;
                        last_synd  = synd(acc0);
                        fixed      = acc0 ^ flip(last_synd);
                        last_data  = {fixed[6], fixed[5], fixed[4], fixed[2]};
                        bitcnt = 0;
                        exp_ws++;
                        done_t = $time;
                    end
                end
            end
        end
    end

    task automatic send(input logic [3:0] d, input logic [2:0] p);
        logic ok;
        ok = 1'b0;
        in_data  = d;
        inj_pos  = p;
        in_valid = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (if0.in_ready) begin
                ok = 1'b1;
                acc_t = $time;
                q0.push_back(enc(d) ^ flip(p));
                q1.push_back(enc(d));
            end else begin
                saw_block = 1'b1;
            end
        end
        chk("accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_ws(input int n);
        for (int i = 0; i < 2000 && exp_ws < n; i++) @(posedge clk);
        #1;
        chk("wait_words", exp_ws, n);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        time t0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", if0.in_ready, 0);
        chk("rst_out_valid", if0.out_valid, 0);
        chk("rst_out_bit", if0.out_bit, 0);
        chk("rst_out_last", if0.out_last, 0);
        chk("rst_out_code", if0.out_code, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", if0.in_ready, 1);

        // Single word, first-bit latency
        ready_fix = 1'b1;
        @(posedge clk);
        #1;
        send(4'b1011, 3'd0);
        @(negedge clk);
        chk("lat_valid", if0.out_valid, 1);
        chk("lat_first_bit", if0.out_bit, 1);
        wait_ws(1);
        chk("w1011_code", last_code0, 7'b101_0101);
        chk("w1011_ws", if0.words_sent, 1);

        // Back-to-back words
        saw_block = 1'b0;
        base = exp_ws;
        send(4'b0000, 3'd0);
        t0 = acc_t;
        send(4'b1111, 3'd0);
        send(4'b0001, 3'd0);
        wait_ws(base + 3);
        chk("b2b_span", 32'(done_t - t0), 210);
        chk("b2b_in_ready_drop", saw_block, 1);
        chk("b2b_last_code", last_code0, 7'b000_0111);

        // Error injection
        base = exp_ws;
        send(4'b1011, 3'd3);
        wait_ws(base + 1);
        chk("inj3_code", last_code0, 7'b101_0001);
        chk("inj3_synd", last_synd, 3);
        chk("inj3_data", last_data, 4'b1011);
        send(4'b1011, 3'd0);
        wait_ws(base + 2);
        chk("inj0_synd", last_synd, 0);
        send(4'b1011, 3'd5);
        wait_ws(base + 3);
        chk("inj5_code", last_code0, 7'b100_0101);
        chk("inj_off_code", last_code1, 7'b101_0101);

        // Random words with random out_ready stalls
        base = exp_ws;
        rnd_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            send(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
        end
        wait_ws(base + 50);
        rnd_ready = 1'b0;
        chk("rand_q_empty", q0.size(), 0);

        // Reset mid-word with HOLD full
        @(posedge clk);
        #1;
        send(4'b0110, 3'd0);
        send(4'b1001, 3'd0);
        for (int i = 0; i < 20 && bitcnt < 3; i++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_bitcnt", bitcnt, 3);
        chk("mid_hold_full", if0.in_ready, 0);
        pulse_reset();
        @(negedge clk);
        chk("mrst_out_valid", if0.out_valid, 0);
        chk("mrst_out_bit", if0.out_bit, 0);
        chk("mrst_out_last", if0.out_last, 0);
        chk("mrst_out_code", if0.out_code, 0);
        chk("mrst_words_sent", if0.words_sent, 0);
        chk("mrst_in_ready", if0.in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_residual", if0.out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(4'b0110, 3'd0);
        wait_ws(1);
        chk("post_rst_code", last_code0, 7'b011_0011);

        // Narrow counter wrap
        @(posedge clk);
        #1;
        pulse_reset();
        for (int k = 1; k <= 5; k++) begin
            send(4'(k), 3'd0);
            wait_ws(k);
            chk("ws_w2_seq", if1.words_sent, k % 4);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hamming_tx_serializer.md
Name: hamming_tx_serializer

Overview:
Transmit-side counterpart of the Hamming(7,4) decoder. It accepts 4-bit data words on a valid/ready handshake and encodes each into a 7-bit codeword with the same parity-check matrix the decoder uses. It serializes each codeword MSB-first onto a 1-bit valid/ready stream, with one word of buffering so that words go out back-to-back. An optional single-bit error injector feeds known faults into the decoder path for test.

Parameters:
INJ_EN, 1, 1 = error injection logic present; 0 = inj_pos ignored (treated as 0)
CNT_W, 8, width of the words_sent counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_data  in  4  data word {w3,w2,w1,w0}
in_valid  in  1  in_data/inj_pos valid
in_ready  out  1  block can accept a word
inj_pos  in  3  error position 1..7 (flip codeword bit inj_pos-1); 0 = no error; sampled with in_data
out_bit  out  1  current serial bit
out_valid  out  1  out_bit valid
out_last  out  1  high with codeword bit 0 (last bit of word)
out_ready  in  1  downstream accepts out_bit
out_code  out  7  full transmitted codeword (after injection) of the word being shifted
words_sent  out  CNT_W  count of completed codewords, wraps

Behaviour:
- Encoding, codeword c[6:0]: c6=w3, c5=w2, c4=w1, c2=w0; c3=w3^w2^w1; c1=w3^w2^w0; c0=w3^w1^w0. Syndrome of an uninjected word is 000. Bit index i corresponds to position i+1.
- Injection: if INJ_EN and inj_pos!=0, invert c[inj_pos-1] before storage. out_code reflects the injected word.
- Storage: shifter (current word, bit index 6..0) plus one holding register (HOLD).
- State: IDLE (shifter empty), SHIFT.
- Input handshake:
  - in_ready = rst_n & !hold_full, derived from flops only.
  - Transfer occurs when in_valid & in_ready at a rising edge.
- Load rules at an edge:
  - If the shifter is free, the accepted word enters the shifter directly; otherwise it enters HOLD.
  - The shifter is free when in IDLE, or when a last-bit transfer (out_valid & out_ready & out_last) occurs on the same edge.
  - If HOLD is full and the shifter frees, HOLD moves to the shifter on that edge and may be refilled on the same edge.
- Latency: a word accepted at edge E into an IDLE shifter presents c6 with out_valid=1 in the cycle after E.
- Throughput: with out_ready held high, one bit per cycle and 7 cycles per word with no gap cycles.
- Output handshake:
  - A bit transfers when out_valid & out_ready.
  - out_bit, out_last and out_code hold stable while out_valid & !out_ready.
  - out_valid is never dropped before its transfer.
- Bit order: c6 first, c0 last. out_last=1 only during c0.
- SHIFT to IDLE occurs when the last bit transfers and HOLD is empty and no word is accepted that edge. out_valid=0 in IDLE.
- words_sent increments by 1 on each last-bit transfer and wraps from 2^CNT_W-1 to 0.
- Reset (rst_n=0 at an edge):
  - out_valid=0, out_bit=0, out_last=0, out_code=0, words_sent=0, HOLD empty, state IDLE.
  - in_ready=0 while rst_n=0 and 1 in the first cycle after release.
  - Reset mid-word discards the partial and held words; no further bits of them are emitted.
- in_valid with in_ready=0: no transfer. The upstream must hold its data.

Test Plan:
- Reset, then in_data=4'b1011, inj_pos=0, out_ready=1 -> out_valid in the next cycle. Serial bits 1,0,1,0,1,0,1, out_code=7'b1010101, out_last on the 7th bit, words_sent=1.
- Back-to-back words 4'b0000, 4'b1111, 4'b0001 with out_ready=1 -> 21 contiguous valid bits: 0000000, 1111111, 0000111. in_ready drops while HOLD is full. words_sent=3.
- Data 4'b1011 with inj_pos=3 -> out_code=7'b1010001. Looped into hamming_decoder, s=3, w=4'b1011. inj_pos=0 gives s=0. With INJ_EN=0, inj_pos=5 gives 7'b1010101.
- out_ready toggled pseudo-randomly, 50 random words -> every codeword is reconstructed bit-exact, bits stay stable during stalls, no bit is dropped or duplicated.
- rst_n pulsed low after the 3rd bit of a word with HOLD full -> outputs are 0 the next cycle, no residual bits, words_sent=0, a new word encodes correctly.
- CNT_W=2, 5 words sent -> words_sent sequence 1,2,3,0,1.
